// File: rtl/comparator_pkg.sv
// Shared constants and types for the registered magnitude comparator.
// Build option COMPARATOR_SIGNED_EN (see comparator_core) switches operands to two's-complement.
package comparator_pkg;

  localparam int CMP_WIDTH = 3;

  typedef enum logic [1:0] {
    CMP_LT,
    CMP_EQ,
    CMP_GT
  } cmp_result_t;

  // Expands a comparison result into the {greater, equal, less} one-hot flags.
  function automatic logic [2:0] cmp_to_onehot(input cmp_result_t res);
    logic [2:0] flags;
    flags = 3'b000;
    case (res)
      CMP_GT:  flags = 3'b100;
      CMP_EQ:  flags = 3'b010;
      CMP_LT:  flags = 3'b001;
      default: flags = 3'b000;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/comparator_3bit_if.sv
// Operand/result bundle between a datapath producer and the comparator.
// master drives operands and observes results; slave is the comparator side.
interface comparator_3bit_if
  import comparator_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             a_greater_b;
  logic             a_equal_b;
  logic             a_less_b;
  logic [WIDTH-1:0] diff_mag;

  modport master (
    output in_valid, a, b,
    input  out_valid, a_greater_b, a_equal_b, a_less_b, diff_mag
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, a_greater_b, a_equal_b, a_less_b, diff_mag
  );

endinterface

// File: rtl/comparator_core.sv
// Combinational compare and absolute difference of two WIDTH-bit operands.
// Define COMPARATOR_SIGNED_EN for two's-complement ordering with a saturating magnitude.
module comparator_core
  import comparator_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output cmp_result_t      result_o,
  output logic [WIDTH-1:0] diff_mag_o
);

`ifdef COMPARATOR_SIGNED_EN
  // One extra bit holds any signed difference, so the magnitude never wraps.
  logic signed [WIDTH:0] a_ext;
  logic signed [WIDTH:0] b_ext;
  logic signed [WIDTH:0] diff_ext;
  logic        [WIDTH:0] mag;

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    result_o   = CMP_EQ;
    diff_mag_o = '0;
    a_ext      = {a_i[WIDTH-1], a_i};
    b_ext      = {b_i[WIDTH-1], b_i};
    diff_ext   = a_ext - b_ext;
    mag        = diff_ext[WIDTH] ? WIDTH'(0) - diff_ext : diff_ext;

    if (a_ext > b_ext) begin
      result_o = CMP_GT;
    end else if (a_ext < b_ext) begin
      result_o = CMP_LT;
    end

    diff_mag_o = mag[WIDTH] ? {WIDTH{1'b1}} : mag[WIDTH-1:0];
  end
`else
  always_comb begin
    result_o   = CMP_EQ;
    diff_mag_o = '0;
    if (a_i > b_i) begin
      result_o   = CMP_GT;
      diff_mag_o = a_i - b_i;
    end else if (a_i < b_i) begin
      result_o   = CMP_LT;
      diff_mag_o = b_i - a_i;
    end
  end
`endif

endmodule

// File: rtl/comparator_3bit.sv
// Registered magnitude comparator: one-cycle latency, one-hot flags and |a-b|.
// Honours COMPARATOR_SIGNED_EN through comparator_core; port list is the same in both builds.
module comparator_3bit
  import comparator_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  comparator_3bit_if.slave  bus
);

  cmp_result_t      core_result;
  logic [WIDTH-1:0] core_diff;

  logic             valid_q, valid_d;
  logic [2:0]       flags_q, flags_d;
  logic [WIDTH-1:0] diff_q,  diff_d;

  comparator_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_i        (bus.a),
    .b_i        (bus.b),
    .result_o   (core_result),
    .diff_mag_o (core_diff)
  );

  // Results only move on an accepted input, so idle operands never reach the outputs.
  always_comb begin
    valid_d = bus.in_valid;
    flags_d = flags_q;
    diff_d  = diff_q;
    if (bus.in_valid) begin
      flags_d = cmp_to_onehot(core_result);
      diff_d  = core_diff;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      flags_q <= 3'b000;
      diff_q  <= '0;
    end else begin
      valid_q <= valid_d;
      flags_q <= flags_d;
      diff_q  <= diff_d;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.a_greater_b = flags_q[2];
  assign bus.a_equal_b   = flags_q[1];
  assign bus.a_less_b    = flags_q[0];
  assign bus.diff_mag    = diff_q;

endmodule

// File: tb/tb_comparator_3bit.sv
// Scoreboard bench for comparator_3bit: driver pushes per-cycle expectations from an
// arithmetic reference model; a monitor pops and compares just after each rising edge.
module tb_comparator_3bit;
  import comparator_pkg::*;

  localparam int W = CMP_WIDTH;

  typedef struct packed {
    logic         valid;
    logic         gt;
    logic         eq;
    logic         lt;
    logic [W-1:0] diff;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  comparator_3bit_if #(.WIDTH(W)) bus ();

  comparator_3bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  exp_t model_q;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".out_valid"}, 32'(bus.out_valid),   32'd0);
    check({tag, ".greater"},   32'(bus.a_greater_b), 32'd0);
    check({tag, ".equal"},     32'(bus.a_equal_b),   32'd0);
    check({tag, ".less"},      32'(bus.a_less_b),    32'd0);
    check({tag, ".diff_mag"},  32'(bus.diff_mag),    32'd0);
  endtask

  // Reference: plain integer ordering and |a-b|, clipped to the largest W-bit value.
  function automatic exp_t ref_capture(input int av, input int bv);
    int   sa, sb, d;
    exp_t e;
    sa = av;
    sb = bv;
`ifdef COMPARATOR_SIGNED_EN
    if (sa >= (1 << (W - 1))) sa = sa - (1 << W);
    if (sb >= (1 << (W - 1))) sb = sb - (1 << W);
`endif
    d = sa - sb;
    if (d < 0) d = -d;
    if (d > (1 << W) - 1) d = (1 << W) - 1;
    e.valid = 1'b1;
    e.gt    = (sa > sb);
    e.eq    = (sa == sb);
    e.lt    = (sa < sb);
    e.diff  = d[W-1:0];
    return e;
  endfunction

  task automatic drive(input bit v, input int av, input int bv);
    int am, bm;
    am = av & ((1 << W) - 1);
    bm = bv & ((1 << W) - 1);
    @(negedge clk);
    bus.in_valid = v;
    bus.a        = am[W-1:0];
    bus.b        = bm[W-1:0];
    if (v) model_q = ref_capture(am, bm);
    else   model_q.valid = 1'b0;
    q.push_back(model_q);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("out_valid", 32'(bus.out_valid),   32'(e.valid));
        check("greater",   32'(bus.a_greater_b), 32'(e.gt));
        check("equal",     32'(bus.a_equal_b),   32'(e.eq));
        check("less",      32'(bus.a_less_b),    32'(e.lt));
        check("diff_mag",  32'(bus.diff_mag),    32'(e.diff));
        if (e.gt | e.eq | e.lt)
          check("onehot", 32'($countones({bus.a_greater_b, bus.a_equal_b, bus.a_less_b})), 32'd1);
      end
    end
  end

  initial begin
    model_q      = '0;
    bus.in_valid = 1'b1;
    bus.a        = W'(5);
    bus.b        = W'(2);

    // Valid operands held during reset must not be captured.
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_hold");

    @(negedge clk);
    rst_n   = 1'b1;
    model_q = ref_capture(5, 2);
    q.push_back(model_q);

    drive(1, 0, 0);
    drive(1, 1, 2);
    drive(1, 3, 2);
    drive(1, 7, 7);
    drive(1, 4, 3);

    drive(1, 6, 1);
    repeat (5) drive(0, int'($urandom), int'($urandom));

    for (int ia = 0; ia < (1 << W); ia++)
      for (int ib = 0; ib < (1 << W); ib++)
        drive(1, ia, ib);

    drive(1, 7, 0);
    drive(1, 0, 7);
    drive(1, 3, 4);

    repeat (200) drive(bit'($urandom_range(0, 1)), int'($urandom), int'($urandom));

    // Reset between edges during back-to-back traffic.
    drive(1, 5, 2);
    drive(1, 2, 5);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #2;
    check_all_zero("reset_no_capture");
    check("reset_queue_empty", 32'(q.size()), 32'd0);

    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    model_q      = '0;
    q.push_back(model_q);
    drive(0, 3, 1);
    drive(1, 7, 0);
    drive(1, 7, 7);
    drive(0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    check("drain", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/comparator_3bit.md
Name: comparator_3bit

Overview:
- Registered magnitude comparator for two WIDTH-bit operands (default 3 bits).
- Produces one-hot greater/equal/less flags plus the absolute difference, one cycle after a valid input.
- Leaf block in the datapath; consumers sample the result when out_valid is high.

Parameters:
- WIDTH, 3, operand width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b are valid this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result registers updated this cycle (1-cycle pulse per accepted input)
- a_greater_b  output  1  A > B
- a_equal_b  output  1  A == B
- a_less_b  output  1  A < B
- diff_mag  output  WIDTH  |A - B|

Behaviour:
- Reset is asynchronous and active-low.
  - While rst_n = 0, all outputs are 0: out_valid, a_greater_b, a_equal_b, a_less_b, diff_mag.
  - Release is synchronous to clk; the first capture is on the first rising edge with rst_n = 1 and in_valid = 1.
- Latency is exactly 1 cycle.
  - On a rising edge with in_valid = 1, all result registers load from a/b, and out_valid = 1 for the following cycle.
  - On a rising edge with in_valid = 0, out_valid = 0; flags and diff_mag hold their previous values.
- Back-to-back in_valid is accepted every cycle. There is no backpressure and no ready signal.
- Flags are one-hot after the first capture: exactly one of greater/equal/less is 1.
  - All three are 0 only between reset and the first capture.
- Comparison is unsigned by default:
  - greater = a > b
  - equal = a == b
  - less = a < b
- diff_mag = (a >= b) ? a - b : b - a, computed at WIDTH bits with no overflow possible.
  - Equal operands give 0. a = 7, b = 0 gives 7.
- Boundary cases: a = b = 0 and a = b = all-ones both give equal = 1 and diff_mag = 0.
- Reset asserted mid-stream clears all outputs immediately, including a pending out_valid. No capture happens while rst_n = 0.
- X on a/b while in_valid = 0 must not propagate to the outputs.

Optional Feature:
- Macro: COMPARATOR_SIGNED_EN.
- When defined:
  - a and b are interpreted as two's-complement (range -4..3 for WIDTH = 3), and the flags follow signed ordering.
  - diff_mag is the signed absolute difference computed at WIDTH+1 bits internally and truncated to WIDTH bits. It saturates to all-ones if the true magnitude exceeds 2^WIDTH - 1.
- When undefined: pure unsigned comparison as above.
- Port list is identical in both builds.

Decomposition:
- Package comparator_pkg holds:
  - default width constant CMP_WIDTH = 3
  - typedef cmp_result_t, an enum {CMP_LT, CMP_EQ, CMP_GT} used internally to drive the one-hot flags
- One combinational sub-module, comparator_core:
  - inputs a, b; outputs cmp_result_t and diff_mag
  - contains the signed/unsigned selection
- comparator_3bit wraps comparator_core with the valid pipeline and output registers.

Test Plan:
- Reset: hold rst_n = 0 with in_valid = 1, a = 5, b = 2 -> all outputs 0. Deassert, one cycle later -> greater = 1, diff_mag = 3, out_valid = 1.
- Directed sequence, one capture per cycle:
  - a = 000, b = 000 -> equal = 1, diff 0
  - a = 001, b = 010 -> less = 1, diff 1
  - a = 011, b = 010 -> greater = 1, diff 1
  - a = 111, b = 111 -> equal = 1, diff 0
  - a = 100, b = 011 -> greater = 1, diff 1 (unsigned). With COMPARATOR_SIGNED_EN: less = 1, diff 7.
- Hold: in_valid pulsed once with a = 6, b = 1, then 5 idle cycles with random a/b -> out_valid 0, flags stay greater = 1, diff_mag 5.
- Exhaustive: all 64 (a, b) pairs back-to-back -> flags one-hot and match a reference model, diff_mag correct, out_valid high each cycle.
- Async reset mid-stream: assert rst_n between clock edges during back-to-back traffic -> outputs clear immediately without waiting for clk.
- Extremes: a = 7, b = 0 -> greater, diff 7. a = 0, b = 7 -> less, diff 7. Signed build: a = 3, b = -4 -> greater, diff saturates to 7.
